// File: rtl/peripheral_operand_pkg.sv
// Shared definitions for the operand-entry peripheral.
//   coll_state_t : collector FSM states (COLLECT while chunks are keyed in,
//                  FULL while a complete set waits for the downstream).
//   chunks()     : number of DATA_W chunks that make up one WORD_W operand.
//   idx_w()      : width of a counter indexing n items, never less than 1.
package peripheral_operand_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } coll_state_t;

    function automatic int chunks(input int word_w, input int data_w);
        return word_w / data_w;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/operand_pulse_sync.sv
// Push-button front end: brings the raw button level into the clk domain
// through two flops and turns each synchronised rising edge into a single
// one-cycle strobe.
//   clk    : system clock
//   reset  : asynchronous, active-high; all flops clear to 0
//   level  : raw, asynchronous button level
//   strobe : one-cycle pulse, high in the cycle after the level reaches sync2
module operand_pulse_sync (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic strobe
);

    logic sync1;
    logic sync2;
    logic prev;
    logic fill1;
    logic fill2;
    logic armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            prev  <= sync2;
            // fill1/fill2 mark when sync2 holds a real post-reset sample
            // rather than its reset value.
            fill1 <= 1'b1;
            fill2 <= fill1;
            // The detector only arms once a genuine low has been seen, so a
            // button already held down when reset is released does not fire
            // until it is released and pressed again.
            if (fill2 && !sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign strobe = sync2 & ~prev & armed;

endmodule

// File: rtl/peripheral_operand_collector.sv
// Operand-entry peripheral: assembles NUM_OPS operands of WORD_W bits from
// DATA_W-bit switch chunks, one chunk per button press, and offers the
// completed set to the downstream datapath with a valid/ready handshake.
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   inputdata  : switch value written on each accepted press
//   enterpulse : raw push-button level
//   clear      : synchronous abort; zeroes operands and indices
//   ops_ready  : downstream accepts the operand set
//   ops_valid  : a complete operand set is held on operands
//   operands   : operand i at [i*WORD_W +: WORD_W]
//   op_idx     : operand currently being filled
//   chunk_idx  : count of chunks already entered into the current operand
module peripheral_operand_collector
    import peripheral_operand_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int WORD_W    = 32,
    parameter int NUM_OPS   = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [DATA_W-1:0]                             inputdata,
    input  logic                                          enterpulse,
    input  logic                                          clear,
    input  logic                                          ops_ready,
    output logic                                          ops_valid,
    output logic [NUM_OPS*WORD_W-1:0]                     operands,
    output logic [idx_w(NUM_OPS)-1:0]                     op_idx,
    output logic [idx_w(chunks(WORD_W, DATA_W))-1:0]      chunk_idx
);

    localparam int CHUNKS = chunks(WORD_W, DATA_W);
    localparam int OW     = idx_w(NUM_OPS);
    localparam int CW     = idx_w(CHUNKS);
    localparam int SLOTS  = NUM_OPS * CHUNKS;

    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
    localparam logic [OW-1:0] LAST_OP    = OW'(NUM_OPS - 1);

    if ((WORD_W % DATA_W) != 0) begin : g_bad_word_w
        $error("WORD_W (%0d) must be a multiple of DATA_W (%0d)", WORD_W, DATA_W);
    end

    if (NUM_OPS < 1) begin : g_bad_num_ops
        $error("NUM_OPS (%0d) must be at least 1", NUM_OPS);
    end

    logic              strobe;
    coll_state_t       state_q;
    coll_state_t       state_d;
    logic [OW-1:0]     op_q;
    logic [OW-1:0]     op_d;
    logic [CW-1:0]     chunk_q;
    logic [CW-1:0]     chunk_d;
    logic              wr_en;
    logic              clr;
    logic [CW-1:0]     slot_sel;
    logic [SLOTS-1:0]  slot_we;
    logic [DATA_W-1:0] slot_q [SLOTS];

    operand_pulse_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .level  (enterpulse),
        .strobe (strobe)
    );

    // FSM state and entry counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            op_q    <= '0;
            chunk_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            chunk_q <= chunk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        chunk_d = chunk_q;
        wr_en   = 1'b0;
        clr     = 1'b0;

        if (clear) begin
            // clear outranks both a strobe and a handshake in the same cycle
            clr     = 1'b1;
            state_d = COLLECT;
            op_d    = '0;
            chunk_d = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (strobe) begin
                        wr_en = 1'b1;
                        if (chunk_q == LAST_CHUNK) begin
                            chunk_d = '0;
                            if (op_q == LAST_OP) begin
                                op_d    = '0;
                                state_d = FULL;
                            end else begin
                                op_d = op_q + OW'(1);
                            end
                        end else begin
                            chunk_d = chunk_q + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (ops_ready) begin
                        state_d = COLLECT;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // Physical slot for the chunk being entered; MSB-first fills from the top.
    assign slot_sel = MSB_FIRST ? (LAST_CHUNK - chunk_q) : chunk_q;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        for (genvar k = 0; k < CHUNKS; k++) begin : g_slot
            assign slot_we[i*CHUNKS + k] = wr_en && (op_q == OW'(i)) && (slot_sel == CW'(k));
            assign operands[i*WORD_W + k*DATA_W +: DATA_W] = slot_q[i*CHUNKS + k];
        end
    end

    // Operand storage; contents persist across a handshake until overwritten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < SLOTS; j++) begin
                slot_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < SLOTS; j++) begin
                if (clr) begin
                    slot_q[j] <= '0;
                end else if (slot_we[j]) begin
                    slot_q[j] <= inputdata;
                end
            end
        end
    end

    assign ops_valid = (state_q == FULL);
    assign op_idx    = op_q;
    assign chunk_idx = chunk_q;

endmodule

// File: tb/tb_peripheral_operand_collector.sv
module tb_peripheral_operand_collector;

    logic        clk;
    logic        reset;

    logic [7:0]  din_a;
    logic        btn_a;
    logic        clr_a;
    logic        rdy_a;
    logic        vld_a;
    logic [63:0] ops_a;
    logic [0:0]  opi_a;
    logic [1:0]  chi_a;

    logic [7:0]  din_b;
    logic        btn_b;
    logic        clr_b;
    logic        rdy_b;
    logic        vld_b;
    logic [47:0] ops_b;
    logic [1:0]  opi_b;
    logic [0:0]  chi_b;

    int checks;
    int errors;
    int strb_cnt;
    int strb_run;
    int strb_max;

    peripheral_operand_collector dut_a (
        .clk        (clk),
        .reset      (reset),
        .inputdata  (din_a),
        .enterpulse (btn_a),
        .clear      (clr_a),
        .ops_ready  (rdy_a),
        .ops_valid  (vld_a),
        .operands   (ops_a),
        .op_idx     (opi_a),
        .chunk_idx  (chi_a)
    );

    peripheral_operand_collector #(
        .DATA_W    (8),
        .WORD_W    (16),
        .NUM_OPS   (3),
        .MSB_FIRST (1'b1)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .inputdata  (din_b),
        .enterpulse (btn_b),
        .clear      (clr_b),
        .ops_ready  (rdy_b),
        .ops_valid  (vld_b),
        .operands   (ops_b),
        .op_idx     (opi_b),
        .chunk_idx  (chi_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe counter and longest run, sampled mid-cycle
    always @(negedge clk) begin
        if (dut_a.u_sync.strobe) begin
            strb_cnt = strb_cnt + 1;
            strb_run = strb_run + 1;
            if (strb_run > strb_max) strb_max = strb_run;
        end else begin
            strb_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_a(input logic [7:0] d, input int hold);
        @(negedge clk);
        din_a = d;
        btn_a = 1'b1;
        repeat (hold) @(negedge clk);
        btn_a = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_b(input logic [7:0] d);
        @(negedge clk);
        din_b = d;
        btn_b = 1'b1;
        repeat (2) @(negedge clk);
        btn_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int base;
        checks   = 0;
        errors   = 0;
        strb_cnt = 0;
        strb_run = 0;
        strb_max = 0;
        reset = 1'b1;
        din_a = '0; btn_a = 1'b0; clr_a = 1'b0; rdy_a = 1'b0;
        din_b = '0; btn_b = 1'b0; clr_b = 1'b0; rdy_b = 1'b0;

        #3;
        chk("rst_valid", vld_a, 0);
        chk("rst_ops", ops_a, 0);
        chk("rst_opidx", opi_a, 0);
        chk("rst_chunk", chi_a, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // LSB-first entry of 0x11..0x77, index tracking after each press
        for (int n = 1; n <= 7; n++) begin
            press_a(8'(8'h11 * n), 2);
            chk("entry_chunk", chi_a, n % 4);
            chk("entry_opidx", opi_a, (n / 4) % 2);
        end

        // final press with ops_valid latency measured edge by edge
        @(negedge clk);
        din_a = 8'h88;
        btn_a = 1'b1;
        @(posedge clk); #1;
        chk("lat_e0", vld_a, 0);
        @(posedge clk); #1;
        chk("lat_e1", vld_a, 0);
        @(posedge clk); #1;
        chk("lat_e2", vld_a, 1);
        @(negedge clk);
        btn_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("set1_op0", ops_a[31:0], 32'h44332211);
        chk("set1_op1", ops_a[63:32], 32'h88776655);
        chk("set1_idx", {opi_a, chi_a}, 0);

        // presses in FULL are ignored
        press_a(8'hFF, 2);
        chk("full_ops", ops_a, 64'h88776655_44332211);
        chk("full_valid", vld_a, 1);
        chk("full_idx", {opi_a, chi_a}, 0);

        // one-cycle handshake
        @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        chk("hs_valid", vld_a, 0);
        chk("hs_idx", {opi_a, chi_a}, 0);
        chk("hs_keep", ops_a, 64'h88776655_44332211);

        // held button: 20 cycles gives one write, then a fresh press
        base = strb_cnt;
        strb_max = 0;
        press_a(8'hA1, 20);
        chk("held_writes", strb_cnt - base, 1);
        chk("held_chunk", chi_a, 1);
        press_a(8'hB2, 2);
        chk("held_total", strb_cnt - base, 2);
        chk("strobe_width", strb_max, 1);
        chk("rebuild_op0", ops_a[31:0], 32'h4433B2A1);

        press_a(8'hC3, 2);
        press_a(8'hD4, 2);
        press_a(8'hE5, 2);
        press_a(8'hF6, 2);
        press_a(8'h07, 2);
        press_a(8'h18, 2);
        chk("set2_ops", ops_a, 64'h1807F6E5_D4C3B2A1);
        chk("set2_valid", vld_a, 1);

        // clear alongside ready in FULL: clear wins
        @(negedge clk);
        clr_a = 1'b1;
        rdy_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        rdy_a = 1'b0;
        chk("clr_rdy_valid", vld_a, 0);
        chk("clr_rdy_ops", ops_a, 0);

        // clear coincident with a strobe
        press_a(8'h01, 2);
        press_a(8'h02, 2);
        press_a(8'h03, 2);
        chk("pre_clr_chunk", chi_a, 3);
        @(negedge clk);
        din_a = 8'h04;
        btn_a = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        btn_a = 1'b0;
        chk("clr_strb_ops", ops_a, 0);
        chk("clr_strb_idx", {opi_a, chi_a}, 0);
        repeat (4) @(negedge clk);
        chk("clr_strb_after", ops_a, 0);

        // MSB-first, 16-bit, three operands
        press_b(8'h12);
        press_b(8'h34);
        chk("b_chunk", chi_b, 0);
        chk("b_opidx", opi_b, 1);
        press_b(8'h56);
        press_b(8'h78);
        press_b(8'h9A);
        press_b(8'hBC);
        chk("b_ops", ops_b, 48'h9ABC_5678_1234);
        chk("b_valid", vld_b, 1);

        // asynchronous reset mid-FULL (B) and mid-entry (A)
        press_a(8'h21, 2);
        press_a(8'h22, 2);
        chk("a_mid_chunk", chi_a, 2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        btn_a = 1'b1;
        #1;
        chk("arst_a_ops", ops_a, 0);
        chk("arst_a_idx", {opi_a, chi_a}, 0);
        chk("arst_b_valid", vld_b, 0);
        chk("arst_b_ops", ops_b, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("held_rst_chunk", chi_a, 0);
        chk("held_rst_ops", ops_a, 0);
        btn_a = 1'b0;
        repeat (4) @(negedge clk);
        press_a(8'h5A, 2);
        chk("post_rst_chunk", chi_a, 1);
        chk("post_rst_ops", ops_a, 64'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peripheral_operand_collector.md
# peripheral_operand_collector

Parametrised operand-entry peripheral. It assembles NUM_OPS operands of WORD_W bits each from DATA_W-bit chunks keyed in on switches, one chunk per press of a raw push-button. It presents the completed set with a valid/ready handshake to the downstream ALU/datapath. It sits between the board I/O (switches, button) and the compute core, and generalises the fixed two-operand, 32-bit, byte-entry collector.

## Interface
- DATA_W, 8: width of one entered chunk (switch count).
- WORD_W, 32: operand width; must be a multiple of DATA_W; CHUNKS = WORD_W/DATA_W.
- NUM_OPS, 2: number of operands collected per set (≥1).
- MSB_FIRST, 0: 0 = first chunk lands in the least-significant slot; 1 = first chunk lands in the most-significant slot.
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- inputdata  in  DATA_W  switch value; sampled on the capture edge.
- enterpulse  in  1  raw, asynchronous push-button level.
- clear  in  1  synchronous abort/clear.
- ops_ready  in  1  downstream accepts the operand set.
- ops_valid  out  1  complete operand set available.
- operands  out  NUM_OPS*WORD_W  flattened; operand i at [i*WORD_W +: WORD_W].
- op_idx  out  max(1,$clog2(NUM_OPS))  operand currently being filled.
- chunk_idx  out  max(1,$clog2(CHUNKS))  next chunk slot count within the operand, for display.

## Operation
- FSM states: COLLECT, FULL.
- COLLECT:
  - Each enter strobe writes inputdata into operand op_idx.
  - Slot number is k = chunk_idx (LSB-first) or CHUNKS-1-chunk_idx (MSB-first); the write covers bits [k*DATA_W +: DATA_W]. Other bits are unchanged.
  - chunk_idx increments and wraps at CHUNKS-1 → 0. On that wrap, op_idx increments.
  - A strobe on the last chunk of operand NUM_OPS-1 writes the chunk, zeroes both indices and moves the FSM to FULL.
- FULL:
  - ops_valid = 1; operands are held stable; enter strobes are ignored (no write, no index change).
  - ops_valid && ops_ready → COLLECT. Operand registers keep their contents until overwritten.
- clear (any state): operands, indices and ops_valid go to 0, state goes to COLLECT. clear has priority over a strobe and over a handshake in the same cycle.
- Reset values: state COLLECT, operands 0, op_idx 0, chunk_idx 0, ops_valid 0, synchroniser flops 0.
- Reset mid-entry discards the partial set. No state survives reset.

## Timing
- enterpulse passes through a 2-flop synchroniser plus a rising-edge detector, producing a one-cycle strobe.
- If the raw level rises before edge E0, sync1 captures it at E0 and sync2 at E1. The strobe is high from E1 to E2, and the write happens at E2 using inputdata sampled at E2. Latency is 2 edges; inputdata must be stable across that window.
- A button held high for any number of cycles produces exactly one strobe. A new strobe requires the level to go low for at least one synchronised cycle.
- ops_valid rises at the same edge as the final write (E2 of the last press), so the full set is visible the cycle after.
- Handshake: the transfer occurs at an edge where ops_valid && ops_ready. ops_valid falls after that edge. ops_ready while ops_valid=0 has no effect. The earliest next strobe accepted is the one at or after the cycle following the transfer.
- No button debounce is performed here; debounce, if needed, sits upstream.

## Structure
- Shared package peripheral_operand_pkg holds:
  - the state enum (COLLECT, FULL);
  - a CHUNKS helper function;
  - the index-width helper (max(1,$clog2(n))).
- Sub-module operand_pulse_sync contains the 2-flop synchroniser and rising-edge detector: inputs clk, reset, level; output strobe; reset 0.
- Top module: FSM, counters, operand register array with generate-indexed slot writes, and an elaboration check that WORD_W % DATA_W == 0.

## Test plan
- Default parameters (LSB-first), 8 presses entering 0x11…0x88:
  - after the 8th write, operands[31:0]=0x44332211 and operands[63:32]=0x88776655;
  - ops_valid=1 exactly 2 edges after the last raw rise;
  - op_idx and chunk_idx step 0..1 and 0..3 during entry.
- Button held for 20 cycles, then released, then pressed again: exactly 2 writes; strobe width is 1 cycle each time.
- In FULL, press with inputdata=0xFF: operands unchanged. Assert ops_ready for 1 cycle: ops_valid drops and indices are 0. The next 8 presses rebuild a new set.
- MSB_FIRST=1, WORD_W=16, NUM_OPS=3, entering 0x12,0x34,0x56,0x78,0x9A,0xBC: operands = {0x9ABC, 0x5678, 0x1234} (op2, op1, op0).
- After 3 presses, assert clear in the same cycle as a strobe: no write, operands=0, indices=0. Repeat with clear alongside ops_ready in FULL: clear wins and ops_valid=0.
- Assert reset asynchronously mid-entry and mid-FULL: all outputs are 0 immediately. After release, a held-high button produces no strobe until it falls and rises again.
